// File: rtl/clint_timer.sv
// Core-local interruptor: free-running 64-bit mtime, mtimecmp and msip exposed as a
// generic-bus slave, driving the core's timer and software interrupt lines.
module clint_timer #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ren,
  input  logic        wen,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  byte_en,
  output logic        busy,
  output logic [31:0] rdata,
  output logic        error,
  output logic [63:0] mtime,
  output logic        timer_int,
  output logic        timer_int_clear,
  output logic        soft_int,
  output logic        soft_int_clear
);

  localparam logic [15:0] OFF_MSIP     = 16'h0000;
  localparam logic [15:0] OFF_CMP_LO   = 16'h4000;
  localparam logic [15:0] OFF_CMP_HI   = 16'h4004;
  localparam logic [15:0] OFF_TIME_LO  = 16'hBFF8;
  localparam logic [15:0] OFF_TIME_HI  = 16'hBFFC;
  localparam logic [15:0] PRESC_LAST   = 16'(TICK_DIV - 1);

  typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_e;

  state_e      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic        msip_q, msip_d;
  logic [31:0] rdata_q, rdata_d;
  logic        error_q, error_d;
  logic        timer_int_q, timer_int_d;
  logic        timer_int_clear_q, timer_int_clear_d;
  logic        soft_int_q, soft_int_d;
  logic        soft_int_clear_q, soft_int_clear_d;

  logic access, in_window, bad, wr_ok, tick;
  logic sel_msip, sel_cmp_lo, sel_cmp_hi, sel_time_lo, sel_time_hi;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int unsigned i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q           <= IDLE;
      presc_q           <= '0;
      mtime_q           <= '0;
      mtimecmp_q        <= '1;
      msip_q            <= 1'b0;
      rdata_q           <= '0;
      error_q           <= 1'b0;
      timer_int_q       <= 1'b0;
      timer_int_clear_q <= 1'b0;
      soft_int_q        <= 1'b0;
      soft_int_clear_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      presc_q           <= presc_d;
      mtime_q           <= mtime_d;
      mtimecmp_q        <= mtimecmp_d;
      msip_q            <= msip_d;
      rdata_q           <= rdata_d;
      error_q           <= error_d;
      timer_int_q       <= timer_int_d;
      timer_int_clear_q <= timer_int_clear_d;
      soft_int_q        <= soft_int_d;
      soft_int_clear_q  <= soft_int_clear_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (ren || wen) state_d = RESP;
      RESP: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy            = (state_q == IDLE);
    rdata           = rdata_q;
    error           = error_q;
    mtime           = mtime_q;
    timer_int       = timer_int_q;
    timer_int_clear = timer_int_clear_q;
    soft_int        = soft_int_q;
    soft_int_clear  = soft_int_clear_q;
  end

  always_comb begin
    access      = (state_q == IDLE) && (ren || wen);
    in_window   = (addr[31:16] == BASE_ADDR[31:16]);
    sel_msip    = (addr[15:0] == OFF_MSIP);
    sel_cmp_lo  = (addr[15:0] == OFF_CMP_LO);
    sel_cmp_hi  = (addr[15:0] == OFF_CMP_HI);
    sel_time_lo = (addr[15:0] == OFF_TIME_LO);
    sel_time_hi = (addr[15:0] == OFF_TIME_HI);
    bad         = !in_window || (addr[1:0] != 2'b00) ||
                  !(sel_msip || sel_cmp_lo || sel_cmp_hi || sel_time_lo || sel_time_hi);
    // ren&wen together is a write; byte_en==0 completes but touches nothing
    wr_ok       = access && wen && !bad && (byte_en != 4'h0);
    tick        = (presc_q == PRESC_LAST);

    presc_d    = tick ? '0 : presc_q + 16'd1;
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    if (wr_ok && sel_msip && byte_en[0]) msip_d = wdata[0];
    if (wr_ok && sel_cmp_lo) mtimecmp_d[31:0]  = merge(mtimecmp_q[31:0], wdata, byte_en);
    if (wr_ok && sel_cmp_hi) mtimecmp_d[63:32] = merge(mtimecmp_q[63:32], wdata, byte_en);

    // A bus write to either mtime word suppresses that edge's increment entirely
    mtime_d = mtime_q;
    if (wr_ok && (sel_time_lo || sel_time_hi)) begin
      if (sel_time_lo) mtime_d[31:0]  = merge(mtime_q[31:0], wdata, byte_en);
      if (sel_time_hi) mtime_d[63:32] = merge(mtime_q[63:32], wdata, byte_en);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end

    rdata_d = '0;
    error_d = 1'b0;
    if (access) begin
      error_d = bad;
      if (!bad && !wen) begin
        if (sel_msip)         rdata_d = {31'd0, msip_q};
        else if (sel_cmp_lo)  rdata_d = mtimecmp_q[31:0];
        else if (sel_cmp_hi)  rdata_d = mtimecmp_q[63:32];
        else if (sel_time_lo) rdata_d = mtime_q[31:0];
        else                  rdata_d = mtime_q[63:32];
      end
    end

    timer_int_d       = (mtime_q >= mtimecmp_q);
    timer_int_clear_d = timer_int_q && !timer_int_d;
    soft_int_d        = msip_q;
    soft_int_clear_d  = soft_int_q && !msip_q;
  end

endmodule
